// File: rtl/uart_rx_capture.sv
// UART receiver (8N1) feeding a first-word-fall-through byte FIFO with registered CTS flow control.
// Define UART_RX_PARITY_EN to receive 8E1 frames; the even-parity result is checked at the stop bit.
module uart_rx_capture #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned FIFO_DEPTH   = 8
) (
  input  logic                         io_clock,
  input  logic                         io_reset,
  input  logic                         io_rxd,
  output logic                         io_cts,
  output logic                         io_data_valid,
  input  logic                         io_data_ready,
  output logic [7:0]                   io_data_payload,
  output logic                         io_frameError,
  output logic                         io_overrun,
  output logic [$clog2(FIFO_DEPTH):0]  io_occupancy
);

  localparam int unsigned    AW        = $clog2(FIFO_DEPTH);
  localparam int unsigned    OW        = AW + 1;
  localparam logic [15:0]    BIT_LOAD  = 16'(CLKS_PER_BIT);
  localparam logic [15:0]    HALF_LOAD = 16'(CLKS_PER_BIT / 2);
  localparam logic [OW-1:0]  FULL_LVL  = OW'(FIFO_DEPTH);
  localparam logic [OW-1:0]  CTS_LVL   = OW'(FIFO_DEPTH - 2);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP,
    BREAK
  } state_t;

  // Reset asserts asynchronously but releases on a clock edge so no flop leaves reset mid-cycle.
  logic [1:0] rst_pipe;
  logic       rst_n;

  always_ff @(posedge io_clock or negedge io_reset) begin
    if (!io_reset) rst_pipe <= '0;
    else           rst_pipe <= {rst_pipe[0], 1'b1};
  end

  assign rst_n = rst_pipe[1];

  logic rxd_meta;
  logic rxd_sync;

  always_ff @(posedge io_clock or negedge rst_n) begin
    if (!rst_n) begin
      rxd_meta <= 1'b1;
      rxd_sync <= 1'b1;
    end else begin
      rxd_meta <= io_rxd;
      rxd_sync <= rxd_meta;
    end
  end

  state_t      state, state_n;
  logic [15:0] cnt, cnt_n;
  logic [2:0]  bit_idx, bit_idx_n;
  logic [7:0]  shreg, shreg_n;
  logic        tick;
  logic        push;
  logic        fe_set;
  logic        parity_ok;

`ifdef UART_RX_PARITY_EN
  logic par_bit, par_bit_n;
  assign parity_ok = ((^shreg) == par_bit);
`else
  assign parity_ok = 1'b1;
`endif

  assign tick = (cnt == 16'd1);

  always_ff @(posedge io_clock or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
`ifdef UART_RX_PARITY_EN
      par_bit <= 1'b0;
`endif
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bit_idx <= bit_idx_n;
      shreg   <= shreg_n;
`ifdef UART_RX_PARITY_EN
      par_bit <= par_bit_n;
`endif
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    bit_idx_n = bit_idx;
    shreg_n   = shreg;
`ifdef UART_RX_PARITY_EN
    par_bit_n = par_bit;
`endif
    push      = 1'b0;
    fe_set    = 1'b0;
    case (state)
      IDLE: begin
        if (!rxd_sync) begin
          state_n = START;
          cnt_n   = HALF_LOAD;
        end
      end
      START: begin
        if (tick) begin
          if (!rxd_sync) begin
            state_n   = DATA;
            cnt_n     = BIT_LOAD;
            bit_idx_n = '0;
          end else begin
            state_n = IDLE;
          end
        end else begin
          cnt_n = cnt - 16'd1;
        end
      end
      DATA: begin
        if (tick) begin
          shreg_n   = {rxd_sync, shreg[7:1]};
          cnt_n     = BIT_LOAD;
          bit_idx_n = bit_idx + 3'd1;
          if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_n = PARITY;
`else
            state_n = STOP;
`endif
          end
        end else begin
          cnt_n = cnt - 16'd1;
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (tick) begin
          par_bit_n = rxd_sync;
          cnt_n     = BIT_LOAD;
          state_n   = STOP;
        end else begin
          cnt_n = cnt - 16'd1;
        end
      end
`endif
      STOP: begin
        if (tick) begin
          if (rxd_sync) begin
            push    = parity_ok;
            fe_set  = !parity_ok;
            state_n = IDLE;
          end else begin
            fe_set  = 1'b1;
            state_n = BREAK;
          end
        end else begin
          cnt_n = cnt - 16'd1;
        end
      end
      BREAK: begin
        if (rxd_sync) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [OW-1:0] count, count_n;
  logic          full;
  logic          pop;
  logic          push_ok;
  logic          overrun_set;

  // A full FIFO still takes the byte when the head leaves in the same cycle.
  assign full        = (count == FULL_LVL);
  assign pop         = io_data_valid && io_data_ready;
  assign push_ok     = push && (!full || pop);
  assign overrun_set = push && full && !pop;

  always_comb begin
    count_n = count;
    if (push_ok && !pop)      count_n = count + 1'b1;
    else if (pop && !push_ok) count_n = count - 1'b1;
  end

  always_ff @(posedge io_clock) begin
    if (push_ok) mem[wr_ptr] <= shreg;
  end

  always_ff @(posedge io_clock or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      io_cts        <= 1'b0;
      io_frameError <= 1'b0;
      io_overrun    <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      count         <= count_n;
      io_cts        <= (count_n >= CTS_LVL);
      io_frameError <= fe_set;
      io_overrun    <= overrun_set;
    end
  end

  assign io_data_valid   = (count != '0);
  assign io_data_payload = io_data_valid ? mem[rd_ptr] : '0;
  assign io_occupancy    = count;

endmodule

// File: tb/tb_uart_rx_capture.sv
// Randomized bench for uart_rx_capture: serial frames driven in, delivered bytes and flag pulses
// compared with a queue-based model of what the receiver should deliver.
module tb_uart_rx_capture;

  localparam int unsigned CPB   = 16;
  localparam int unsigned DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst_in;
  logic       rxd;
  logic       cts;
  logic       valid;
  logic       frame_err;
  logic       overrun;
  logic [7:0] payload;
  logic [3:0] occ;
  logic       ready;
  logic       ready_fixed;
  logic       ready_rand;
  logic       rand_en;

  assign ready = rand_en ? ready_rand : ready_fixed;

  always #5 clk = ~clk;

  uart_rx_capture #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .io_clock       (clk),
    .io_reset       (rst_in),
    .io_rxd         (rxd),
    .io_cts         (cts),
    .io_data_valid  (valid),
    .io_data_ready  (ready),
    .io_data_payload(payload),
    .io_frameError  (frame_err),
    .io_overrun     (overrun),
    .io_occupancy   (occ)
  );

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
    n_checks++;
    if (got_v !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got_v, exp_v);
    end
  endtask

  logic [7:0]  got_q[$];
  int unsigned fe_cnt = 0;
  int unsigned ov_cnt = 0;

  always @(negedge clk) begin
    if (rst_in) begin
      if (valid && ready) got_q.push_back(payload);
      if (frame_err) fe_cnt++;
      if (overrun) ov_cnt++;
    end
  end

  initial begin
    ready_rand = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      ready_rand = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] got_at(input int unsigned idx);
    if (idx < got_q.size()) return got_q[idx];
    return 8'hxx;
  endfunction

  task automatic send_bit(input logic b);
    rxd = b;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int unsigned n);
    rxd = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_head(input logic [7:0] d);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_v);
    send_head(d);
`ifdef UART_RX_PARITY_EN
    send_bit(^d);
`endif
    send_bit(stop_v);
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic send_frame_par(input logic [7:0] d, input logic par_v);
    send_head(d);
    send_bit(par_v);
    send_bit(1'b1);
  endtask
`endif

  int unsigned base, fe0, ov0, exp_occ;
  logic [7:0]  exp_q[$];
  logic [7:0]  d;

  initial begin
    rst_in      = 1'b0;
    rxd         = 1'b1;
    ready_fixed = 1'b1;
    rand_en     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", valid, 0);
    check("rst_payload", payload, 0);
    check("rst_fe", frame_err, 0);
    check("rst_ov", overrun, 0);
    check("rst_occ", occ, 0);
    check("rst_cts", cts, 0);
    rst_in = 1'b1;
    idle(5);

    // Single byte 0x55
    base = got_q.size(); fe0 = fe_cnt; ov0 = ov_cnt;
    send_frame(8'h55, 1'b1);
    idle(2 * CPB);
    check("b55_count", got_q.size() - base, 1);
    check("b55_data", got_at(base), 8'h55);
    check("b55_fe", fe_cnt - fe0, 0);
    check("b55_ov", ov_cnt - ov0, 0);

    // Quarter-bit glitch is a false start
    base = got_q.size(); fe0 = fe_cnt;
    rxd = 1'b0;
    repeat (CPB / 4) @(posedge clk);
    #1;
    idle(3 * CPB);
    check("glitch_push", got_q.size() - base, 0);
    check("glitch_fe", fe_cnt - fe0, 0);
    send_frame(8'h5A, 1'b1);
    idle(2 * CPB);
    check("glitch_next", got_at(base), 8'h5A);

    // Bad stop bit with line held low for three bit times
    base = got_q.size(); fe0 = fe_cnt;
    send_head(8'hA3);
`ifdef UART_RX_PARITY_EN
    send_bit(^8'hA3);
`endif
    rxd = 1'b0;
    repeat (3 * CPB) @(posedge clk);
    #1;
    idle(2 * CPB);
    check("brk_fe", fe_cnt - fe0, 1);
    check("brk_push", got_q.size() - base, 0);
    send_frame(8'h3C, 1'b1);
    idle(2 * CPB);
    check("brk_next_count", got_q.size() - base, 1);
    check("brk_next_data", got_at(base), 8'h3C);
    check("brk_next_fe", fe_cnt - fe0, 1);

    // Random bytes, random gaps, random ready
    base = got_q.size(); fe0 = fe_cnt; ov0 = ov_cnt;
    exp_q.delete();
    rand_en = 1'b1;
    for (int n = 0; n < 24; n++) begin
      d = 8'($urandom);
      idle($urandom_range(0, 20));
      send_frame(d, 1'b1);
      exp_q.push_back(d);
    end
    for (int i = 0; i < 300 && valid; i++) begin
      @(posedge clk);
      #1;
    end
    rand_en = 1'b0;
    check("rand_drained", valid, 0);
    check("rand_count", got_q.size() - base, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) check("rand_byte", got_at(base + i), exp_q[i]);
    check("rand_fe", fe_cnt - fe0, 0);
    check("rand_ov", ov_cnt - ov0, 0);

    // Fill with ready low: flow control, saturation and overrun
    idle(CPB);
    ready_fixed = 1'b0;
    base = got_q.size(); ov0 = ov_cnt;
    for (int k = 1; k <= 10; k++) begin
      send_frame(8'(k - 1), 1'b1);
      exp_occ = (k < DEPTH) ? k : DEPTH;
      check("fill_occ", occ, exp_occ);
      check("fill_cts", cts, (exp_occ >= DEPTH - 2) ? 1 : 0);
      check("fill_valid", valid, 1);
      check("fill_head", payload, 8'h00);
      check("fill_ov", ov_cnt - ov0, (k > DEPTH) ? k - DEPTH : 0);
    end
    ready_fixed = 1'b1;
    for (int i = 0; i < 50 && valid; i++) begin
      @(posedge clk);
      #1;
    end
    check("drain_occ", occ, 0);
    check("drain_cts", cts, 0);
    check("drain_count", got_q.size() - base, DEPTH);
    for (int i = 0; i < DEPTH; i++) check("drain_byte", got_at(base + i), i);
    check("drain_ov", ov_cnt - ov0, 2);

    // Reset during data bit 4 of 0xFF with one byte waiting in the FIFO
    ready_fixed = 1'b0;
    send_frame(8'hEE, 1'b1);
    check("pre_rst_occ", occ, 1);
    base = got_q.size(); fe0 = fe_cnt;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    rxd = 1'b1;
    repeat (CPB / 2) @(posedge clk);
    #1;
    rst_in = 1'b0;
    #2;
    check("mid_rst_occ", occ, 0);
    check("mid_rst_valid", valid, 0);
    check("mid_rst_payload", payload, 0);
    repeat (3) @(posedge clk);
    #1;
    rst_in = 1'b1;
    ready_fixed = 1'b1;
    idle(8 * CPB);
    send_frame(8'h81, 1'b1);
    idle(2 * CPB);
    check("post_rst_count", got_q.size() - base, 1);
    check("post_rst_data", got_at(base), 8'h81);
    check("post_rst_fe", fe_cnt - fe0, 0);

`ifdef UART_RX_PARITY_EN
    base = got_q.size(); fe0 = fe_cnt;
    send_frame_par(8'h07, 1'b0);
    idle(2 * CPB);
    check("par_bad_fe", fe_cnt - fe0, 1);
    check("par_bad_push", got_q.size() - base, 0);
    send_frame_par(8'h07, 1'b1);
    idle(2 * CPB);
    check("par_good_count", got_q.size() - base, 1);
    check("par_good_data", got_at(base), 8'h07);
    check("par_good_fe", fe_cnt - fe0, 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
